matrix_entry_controller: RTL and testbench
==========================================

Name: matrix_entry_controller

Overview:
- Sequences keypad entry of one DIM x DIM matrix.
- Consumes the registered keystrobe/keycode stream and accumulates decimal digits into an element value.
- On ENTER, issues a one-cycle write of the value to the element store, then advances row-major through the matrix.
- Sits between the keypad decoder and the matrix register file; a done pulse hands control to the operation unit.

Parameters:
- DIM, 3, matrix dimension (rows = cols = DIM), 2..4
- VAL_W, 8, element value width, unsigned
- MAX_DIGITS, 3, maximum decimal digits accepted per element
- IDX_W, $clog2(DIM), row/col index width (derived, localparam)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- keystrobe  in  1  one-cycle pulse: keycode valid
- keycode  in  4  0-9 digit, 4'hA ENTER, 4'hB CLEAR, 4'hC START; others ignored
- busy  out  1  high in any state other than IDLE
- acc_value  out  VAL_W  value being entered (for display)
- digit_cnt  out  $clog2(MAX_DIGITS+1)  digits accepted for the current element
- wr_en  out  1  one-cycle element write strobe
- wr_row  out  IDX_W  write row index
- wr_col  out  IDX_W  write column index
- wr_data  out  VAL_W  write data
- done  out  1  one-cycle pulse after the final element is written
- abort  out  1  one-cycle pulse when entry is cancelled

Behaviour:
- Reset (async, rst=1): state=IDLE; acc_value, digit_cnt, wr_en, wr_row, wr_col, wr_data, done, abort, busy all 0.
- All outputs are registered. Each keystrobe is acted on in its own cycle; results are visible the next cycle.
- FSM states: IDLE, ENTRY, WRITE, DONE.
- IDLE:
  - START -> ENTRY; row=col=0, acc=0, cnt=0.
  - All other keys ignored.
- ENTRY, digit d:
  - If cnt < MAX_DIGITS: acc = min(acc*10 + d, 2^VAL_W-1) (saturating; compute in VAL_W+4 bits); cnt++.
  - If cnt == MAX_DIGITS: digit ignored.
- ENTRY, ENTER:
  - cnt == 0: ignored.
  - Otherwise -> WRITE.
- ENTRY, CLEAR:
  - cnt > 0: acc=0, cnt=0, stay in ENTRY.
  - cnt == 0: abort=1 for one cycle, -> IDLE. Elements already written are not undone.
- ENTRY, START: ignored.
- WRITE (exactly one cycle):
  - wr_en=1 with wr_row/wr_col = current index and wr_data = acc.
  - Then acc=0, cnt=0.
  - If row==DIM-1 and col==DIM-1 -> DONE.
  - Else col++; if col wraps past DIM-1, col=0 and row++; -> ENTRY.
- DONE (one cycle): done=1, row/col reset to 0, -> IDLE.
- Keystrobes arriving in the WRITE or DONE cycle are dropped. Not buffered.
- wr_en, done and abort are never high outside their single cycle. wr_row/wr_col hold their last value when wr_en=0.
- Reset asserted mid-entry: immediate return to IDLE, no write or done pulse, partial value discarded.
- Keycodes 4'hD-4'hF ignored in every state.

Decomposition:
- Package matrix_pkg:
  - keycode constants KEY_ENTER=4'hA, KEY_CLEAR=4'hB, KEY_START=4'hC
  - entry_state_t enum {IDLE, ENTRY, WRITE, DONE}
- Optional sub-module digit_accumulator: saturating acc*10+d with digit counting, clear and limit inputs, registered output.
- The FSM and row/col counters stay in the top module.

Test Plan:
- Reset, START, keys 1, 2, ENTER -> one cycle later wr_en=1, wr_row=0, wr_col=0, wr_data=12; acc_value and digit_cnt return to 0.
- START, 9, 9, 9, 9 (VAL_W=8) -> acc saturates at 255, 4th digit ignored, digit_cnt=3; ENTER writes 255.
- START, then 9 elements each entered as digit k followed by ENTER:
  - writes land at (0,0),(0,1),(0,2),(1,0)...(2,2) with data 0..8.
  - done pulses one cycle after the 9th write; busy drops next cycle.
- START, ENTER with no digits -> no write; 5, CLEAR, CLEAR -> acc=0 then abort pulse, state IDLE, no wr_en.
- START, 4, 7, rst pulse -> all outputs 0 immediately; a later START writes first to (0,0).
- Keystrobe with digit during the WRITE cycle -> dropped; next element's acc_value stays 0.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix entry controller.
// Keypad command codes, the entry FSM state type and a digit classifier.
package matrix_pkg;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;
    localparam logic [3:0] KEY_START = 4'hC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } entry_state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/matrix_entry_controller_if.sv
// Keypad-side and element-store-side signals of the matrix entry controller.
//   keystrobe/keycode         : registered key stream from the keypad decoder
//   busy/acc_value/digit_cnt  : status for display
//   wr_en/wr_row/wr_col/wr_data : element write port toward the matrix register file
//   done/abort                : single-cycle completion / cancellation pulses
// master = keypad/consumer side, slave = controller.
interface matrix_entry_controller_if #(
    parameter int DIM        = 3,
    parameter int VAL_W      = 8,
    parameter int MAX_DIGITS = 3
);
    localparam int IDX_W = $clog2(DIM);
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    logic             keystrobe;
    logic [3:0]       keycode;
    logic             busy;
    logic [VAL_W-1:0] acc_value;
    logic [CNT_W-1:0] digit_cnt;
    logic             wr_en;
    logic [IDX_W-1:0] wr_row;
    logic [IDX_W-1:0] wr_col;
    logic [VAL_W-1:0] wr_data;
    logic             done;
    logic             abort;

    modport master (
        output keystrobe, keycode,
        input  busy, acc_value, digit_cnt, wr_en, wr_row, wr_col, wr_data, done, abort
    );

    modport slave (
        input  keystrobe, keycode,
        output busy, acc_value, digit_cnt, wr_en, wr_row, wr_col, wr_data, done, abort
    );

endinterface

// File: rtl/matrix_entry_controller_digit_accumulator.sv
// Decimal digit accumulator for one matrix element.
//   clk, rst     : clock, async active-high reset
//   clear        : zero value and digit count (priority over digit_valid)
//   digit_valid  : accept digit this cycle (ignored once MAX_DIGITS reached)
//   digit        : decimal digit 0-9
//   acc          : registered value, saturating at 2^VAL_W-1
//   cnt          : registered count of digits accepted
module digit_accumulator #(
    parameter int VAL_W      = 8,
    parameter int MAX_DIGITS = 3,
    parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             digit_valid,
    input  logic [3:0]       digit,
    output logic [VAL_W-1:0] acc,
    output logic [CNT_W-1:0] cnt
);

    // acc*10+9 always fits in four extra bits, so overflow shows up in the top nibble
    localparam int SUM_W = VAL_W + 4;

    logic [VAL_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] sum;

    always_comb begin
        sum   = SUM_W'(acc_q) * SUM_W'(10) + SUM_W'(digit);
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (digit_valid && (cnt_q < CNT_W'(MAX_DIGITS))) begin
            acc_d = (|sum[SUM_W-1:VAL_W]) ? {VAL_W{1'b1}} : sum[VAL_W-1:0];
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc = acc_q;
    assign cnt = cnt_q;

endmodule

// File: rtl/matrix_entry_controller.sv
// Keypad entry sequencer for one DIM x DIM matrix.
// Accumulates decimal digits per element, writes each element on ENTER and
// walks the matrix row-major, pulsing done after the last element.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of matrix_entry_controller_if (key stream in,
//              status, element write port and done/abort pulses out)
//
// state | meaning
// IDLE  | waiting for START
// ENTRY | collecting digits for element (row, col)
// WRITE | single cycle with wr_en high, then advance index
// DONE  | single cycle with done high, then back to IDLE
module matrix_entry_controller
    import matrix_pkg::*;
#(
    parameter int DIM        = 3,
    parameter int VAL_W      = 8,
    parameter int MAX_DIGITS = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    matrix_entry_controller_if.slave   bus
);

    localparam int IDX_W = $clog2(DIM);
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

    entry_state_t     state_q, state_d;
    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_q, col_d;
    logic             busy_q, busy_d;
    logic             wr_en_q, wr_en_d;
    logic [IDX_W-1:0] wr_row_q, wr_row_d;
    logic [IDX_W-1:0] wr_col_q, wr_col_d;
    logic [VAL_W-1:0] wr_data_q, wr_data_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;

    logic             acc_clear;
    logic             acc_digit;
    logic [VAL_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    digit_accumulator #(
        .VAL_W      (VAL_W),
        .MAX_DIGITS (MAX_DIGITS),
        .CNT_W      (CNT_W)
    ) u_acc (
        .clk         (clk),
        .rst         (rst),
        .clear       (acc_clear),
        .digit_valid (acc_digit),
        .digit       (bus.keycode),
        .acc         (acc),
        .cnt         (cnt)
    );

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        wr_en_d   = 1'b0;
        wr_row_d  = wr_row_q;
        wr_col_d  = wr_col_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        acc_clear = 1'b0;
        acc_digit = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.keystrobe && bus.keycode == KEY_START) begin
                    state_d   = ENTRY;
                    row_d     = '0;
                    col_d     = '0;
                    acc_clear = 1'b1;
                end
            end

            ENTRY: begin
                if (bus.keystrobe) begin
                    if (is_digit(bus.keycode)) begin
                        acc_digit = 1'b1;
                    end else if (bus.keycode == KEY_ENTER && cnt != '0) begin
                        state_d   = WRITE;
                        wr_en_d   = 1'b1;
                        wr_row_d  = row_q;
                        wr_col_d  = col_q;
                        wr_data_d = acc;
                    end else if (bus.keycode == KEY_CLEAR) begin
                        acc_clear = 1'b1;
                        // CLEAR on an empty element cancels the whole entry
                        if (cnt == '0) begin
                            abort_d = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end

            WRITE: begin
                acc_clear = 1'b1;
                if (row_q == LAST_IDX && col_q == LAST_IDX) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ENTRY;
                    if (col_q == LAST_IDX) begin
                        col_d = '0;
                        row_d = row_q + IDX_W'(1);
                    end else begin
                        col_d = col_q + IDX_W'(1);
                    end
                end
            end

            DONE: begin
                row_d   = '0;
                col_d   = '0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_row_q  <= '0;
            wr_col_q  <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            wr_row_q  <= wr_row_d;
            wr_col_q  <= wr_col_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.acc_value = acc;
    assign bus.digit_cnt = cnt;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_row    = wr_row_q;
    assign bus.wr_col    = wr_col_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.done      = done_q;
    assign bus.abort     = abort_q;

endmodule

// File: tb/tb_matrix_entry_controller.sv
module tb_matrix_entry_controller;
    import matrix_pkg::*;

    logic clk;
    logic rst;

    matrix_entry_controller_if #(.DIM(3), .VAL_W(8), .MAX_DIGITS(3)) bus ();

    matrix_entry_controller #(.DIM(3), .VAL_W(8), .MAX_DIGITS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       strobe;
        logic [3:0] key;
        logic [7:0] exp_acc;
        logic [1:0] exp_cnt;
        logic       exp_busy;
        logic       exp_abort;
        logic       push;
        logic [1:0] wr_r;
        logic [1:0] wr_c;
        logic [7:0] wr_d;
    } vec_t;

    typedef struct {
        logic [1:0] r;
        logic [1:0] c;
        logic [7:0] d;
    } wr_t;

    vec_t vecs[$];
    wr_t  exp_q[$];
    wr_t  mon_e;

    int checks     = 0;
    int errors     = 0;
    int done_seen  = 0;
    int abort_seen = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
        end
    endtask

    // called at a negedge; leaves the bench at the following negedge
    task automatic key_now(input logic [3:0] k);
        bus.keystrobe = 1'b1;
        bus.keycode   = k;
        @(negedge clk);
        bus.keystrobe = 1'b0;
    endtask

    task automatic expect_write(input int r, input int c, input int d);
        wr_t w;
        w.r = 2'(r);
        w.c = 2'(c);
        w.d = 8'(d);
        exp_q.push_back(w);
    endtask

    task automatic add(input logic s, input logic [3:0] k, input int a, input int n,
                       input logic b, input logic ab);
        vec_t v;
        v.strobe = s; v.key = k; v.exp_acc = 8'(a); v.exp_cnt = 2'(n);
        v.exp_busy = b; v.exp_abort = ab; v.push = 1'b0;
        v.wr_r = 2'd0; v.wr_c = 2'd0; v.wr_d = 8'd0;
        vecs.push_back(v);
    endtask

    // write scoreboard: every wr_en pulse must match the oldest expected write
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.done)  done_seen++;
            if (bus.abort) abort_seen++;
            if (bus.wr_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write got row=%0d col=%0d data=%0d want no write",
                             bus.wr_row, bus.wr_col, bus.wr_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (bus.wr_row !== mon_e.r || bus.wr_col !== mon_e.c || bus.wr_data !== mon_e.d) begin
                        errors++;
                        $display("FAIL write got row=%0d col=%0d data=%0d want row=%0d col=%0d data=%0d",
                                 bus.wr_row, bus.wr_col, bus.wr_data, mon_e.r, mon_e.c, mon_e.d);
                    end
                end
            end
        end
    end

    initial begin
        rst           = 1'b1;
        bus.keystrobe = 1'b0;
        bus.keycode   = 4'h0;

        @(negedge clk);
        @(negedge clk);
        chk("reset_state", {bus.busy, bus.acc_value, bus.digit_cnt, bus.wr_en, bus.wr_row,
                            bus.wr_col, bus.wr_data, bus.done, bus.abort}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // strobe, key, acc, cnt, busy, abort
        add(1, KEY_START, 0,   0, 1, 0);
        add(1, 4'd1,      1,   1, 1, 0);
        add(1, 4'd2,      12,  2, 1, 0);
        add(1, 4'd3,      123, 3, 1, 0);
        add(1, 4'd4,      123, 3, 1, 0);   // fourth digit ignored
        add(1, KEY_CLEAR, 0,   0, 1, 0);
        add(1, 4'd9,      9,   1, 1, 0);
        add(1, 4'd9,      99,  2, 1, 0);
        add(1, 4'd9,      255, 3, 1, 0);   // 999 saturates
        add(1, 4'd9,      255, 3, 1, 0);
        add(1, 4'hD,      255, 3, 1, 0);
        add(1, KEY_START, 255, 3, 1, 0);
        add(1, KEY_ENTER, 255, 3, 1, 0);   // WRITE cycle
        vecs[vecs.size()-1].push = 1'b1;
        vecs[vecs.size()-1].wr_d = 8'd255;
        add(0, 4'h0,      0,   0, 1, 0);
        add(1, KEY_ENTER, 0,   0, 1, 0);   // no digits: no write
        add(1, 4'd5,      5,   1, 1, 0);
        add(1, KEY_CLEAR, 0,   0, 1, 0);
        add(1, KEY_CLEAR, 0,   0, 0, 1);   // abort
        add(0, 4'h0,      0,   0, 0, 0);
        add(1, KEY_ENTER, 0,   0, 0, 0);
        add(1, 4'd7,      0,   0, 0, 0);
        add(1, 4'hF,      0,   0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].push) expect_write(vecs[i].wr_r, vecs[i].wr_c, vecs[i].wr_d);
            if (vecs[i].strobe) key_now(vecs[i].key);
            else @(negedge clk);
            chk($sformatf("vec%0d", i),
                {bus.acc_value, bus.digit_cnt, bus.busy, bus.abort},
                {vecs[i].exp_acc, vecs[i].exp_cnt, vecs[i].exp_busy, vecs[i].exp_abort});
        end

        // 1, 2, ENTER writes 12 to (0,0); value clears after the write cycle
        key_now(KEY_START);
        key_now(4'd1);
        key_now(4'd2);
        expect_write(0, 0, 12);
        key_now(KEY_ENTER);
        chk("write_strobe", {bus.wr_en, bus.wr_data}, {1'b1, 8'd12});
        @(negedge clk);
        chk("acc_after_write", {bus.wr_en, bus.acc_value, bus.digit_cnt}, 32'd0);
        key_now(KEY_CLEAR);                    // empty element: abort

        // full 3x3 row-major walk
        key_now(KEY_START);
        for (int k = 0; k < 9; k++) begin
            key_now(4'(k));
            expect_write(k / 3, k % 3, k);
            key_now(KEY_ENTER);
            if (k < 8) @(negedge clk);
        end
        @(negedge clk);
        chk("done_pulse", {bus.done, bus.busy}, 2'b11);
        @(negedge clk);
        chk("done_then_idle", {bus.done, bus.busy}, 2'b00);

        // digit during the WRITE cycle is dropped
        key_now(KEY_START);
        key_now(4'd3);
        expect_write(0, 0, 3);
        key_now(KEY_ENTER);
        key_now(4'd5);
        chk("drop_in_write", {bus.acc_value, bus.digit_cnt, bus.busy}, {8'd0, 2'd0, 1'b1});
        key_now(KEY_CLEAR);                    // abort

        // async reset mid-entry discards the partial value
        key_now(KEY_START);
        key_now(4'd4);
        expect_write(0, 0, 4);
        key_now(KEY_ENTER);
        @(negedge clk);
        key_now(4'd7);
        chk("partial_before_rst", bus.acc_value, 8'd7);
        #2 rst = 1'b1;
        #1;
        chk("async_reset", {bus.busy, bus.acc_value, bus.digit_cnt, bus.wr_en, bus.wr_row,
                            bus.wr_col, bus.wr_data, bus.done, bus.abort}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        key_now(KEY_START);
        key_now(4'd8);
        expect_write(0, 0, 8);
        key_now(KEY_ENTER);
        chk("post_reset_write", {bus.wr_en, bus.wr_row, bus.wr_col}, {1'b1, 2'd0, 2'd0});
        @(negedge clk);
        @(negedge clk);

        chk("done_count", done_seen, 1);
        chk("abort_count", abort_seen, 3);
        chk("writes_pending", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
